// File: rtl/video_pixel_feeder.sv
// video_pixel_feeder
//   Aligns a streamed RGB pixel source to raster timing from sync_vg. Pixels
//   are written into a FIFO tagged with a start-of-frame bit; a small FSM pops
//   them in step with active video and keeps the source locked to frame
//   boundaries, dropping or holding data when the two disagree.
//
// Ports
//   clk, reset                pixel clock, asynchronous active-low reset
//   px_data/px_sof/px_valid   source pixel, frame-start tag, write request
//   px_ready                  FIFO not full
//                             Handshake: a pixel is written on a rising clk
//                             edge where px_valid && px_ready; px_data/px_sof
//                             must be stable while px_valid is high.
//   vs_in/hs_in/de_in/x_in/y_in   raster timing from sync_vg
//   vs_out/hs_out/de_out      timing delayed by one clock
//   r_out/g_out/b_out         pixel aligned with de_out, 0 when not streaming
//   fill_level                FIFO occupancy
//   locked                    FSM is in STREAM
//   underflow_cnt/resync_cnt  saturating event counters
//   dbg_state                 current FSM state (0 SEEK, 1 WAIT_FRAME, 2 STREAM)
module video_pixel_feeder #(
    parameter int B       = 8,
    parameter int X_BITS  = 12,
    parameter int Y_BITS  = 12,
    parameter int FIFO_AW = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3*B-1:0]      px_data,
    input  logic                px_sof,
    input  logic                px_valid,
    output logic                px_ready,
    input  logic                vs_in,
    input  logic                hs_in,
    input  logic                de_in,
    input  logic [X_BITS-1:0]   x_in,
    input  logic [Y_BITS-1:0]   y_in,
    output logic                vs_out,
    output logic                hs_out,
    output logic                de_out,
    output logic [B-1:0]        r_out,
    output logic [B-1:0]        g_out,
    output logic [B-1:0]        b_out,
    output logic [FIFO_AW:0]    fill_level,
    output logic                locked,
    output logic [7:0]          underflow_cnt,
    output logic [7:0]          resync_cnt,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        SEEK       = 2'd0,
        WAIT_FRAME = 2'd1,
        STREAM     = 2'd2
    } state_t;

    // Each entry is {sof, rgb}.
    logic [3*B:0]       mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;

    state_t             state_q, state_d;
    logic [3*B-1:0]     rgb_q, rgb_d;
    logic               vs_q, hs_q, de_q, locked_q;
    logic [7:0]         under_q, resync_q;

    logic               empty, push, pop, origin, head_sof;
    logic               under_inc, resync_inc;
    logic [3*B:0]       head;
    logic [3*B-1:0]     head_rgb;

    assign px_ready = (count_q != CW'(DEPTH));
    assign push     = px_valid && px_ready;
    assign empty    = (count_q == '0);
    // Head is only meaningful when non-empty; a push into an empty FIFO lands
    // at rd_ptr and becomes visible the following cycle.
    assign head     = mem_q[rd_ptr_q];
    assign head_sof = head[3*B];
    assign head_rgb = head[3*B-1:0];
    assign origin   = de_in && (x_in == '0) && (y_in == '0);
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        rgb_d      = '0;
        under_inc  = 1'b0;
        resync_inc = 1'b0;
        case (state_q)
            SEEK: begin
                // Flush stale pixels until a frame start reaches the head.
                if (!empty) begin
                    if (head_sof) state_d = WAIT_FRAME;
                    else          pop     = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (origin && !empty) begin
                    pop     = 1'b1;
                    rgb_d   = head_rgb;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (de_in) begin
                    if (empty) begin
                        under_inc = 1'b1;
                    end else if (head_sof && !origin) begin
                        // Source started a new frame early: hold it for the next origin.
                        resync_inc = 1'b1;
                        state_d    = WAIT_FRAME;
                    end else if (origin && !head_sof) begin
                        // Source frame ran long: leftovers must be flushed.
                        resync_inc = 1'b1;
                        state_d    = SEEK;
                    end else begin
                        pop   = 1'b1;
                        rgb_d = head_rgb;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {px_sof, px_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= SEEK;
            rgb_q    <= '0;
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
            under_q  <= '0;
            resync_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            state_q  <= state_d;
            rgb_q    <= rgb_d;
            vs_q     <= vs_in;
            hs_q     <= hs_in;
            de_q     <= de_in;
            locked_q <= (state_d == STREAM);
            if (under_inc && under_q != 8'hFF)   under_q  <= under_q + 8'd1;
            if (resync_inc && resync_q != 8'hFF) resync_q <= resync_q + 8'd1;
        end
    end

    assign vs_out        = vs_q;
    assign hs_out        = hs_q;
    assign de_out        = de_q;
    assign r_out         = rgb_q[3*B-1:2*B];
    assign g_out         = rgb_q[2*B-1:B];
    assign b_out         = rgb_q[B-1:0];
    assign fill_level    = count_q;
    assign locked        = locked_q;
    assign underflow_cnt = under_q;
    assign resync_cnt    = resync_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// tb_video_pixel_feeder
//   Directed bench for video_pixel_feeder on an 8x4 active raster
//   (12 clocks per line, 2 vertical blanking lines).
module tb_video_pixel_feeder;

    localparam int B  = 8;
    localparam int XB = 12;
    localparam int YB = 12;
    localparam int AW = 11;

    logic            clk;
    logic            reset;
    logic [3*B-1:0]  px_data;
    logic            px_sof;
    logic            px_valid;
    logic            px_ready;
    logic            vs_in, hs_in, de_in;
    logic [XB-1:0]   x_in;
    logic [YB-1:0]   y_in;
    logic            vs_out, hs_out, de_out;
    logic [B-1:0]    r_out, g_out, b_out;
    logic [AW:0]     fill_level;
    logic            locked;
    logic [7:0]      underflow_cnt, resync_cnt;
    logic [1:0]      dbg_state;

    int              checks = 0;
    int              errors = 0;
    logic [23:0]     exp_pix [32];
    int              accepted;

    video_pixel_feeder #(.B(B), .X_BITS(XB), .Y_BITS(YB), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .px_data(px_data), .px_sof(px_sof), .px_valid(px_valid), .px_ready(px_ready),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .x_in(x_in), .y_in(y_in),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .fill_level(fill_level), .locked(locked),
        .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int n);
        logic [7:0] v;
        v = n[7:0];
        return {v, v ^ 8'hA5, ~v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; x_in = '0; y_in = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [23:0] d, input logic sof);
        px_valid = 1'b1; px_data = d; px_sof = sof;
        step();
        px_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        step();
    endtask

    // One frame; exp_pix[] gives the expected rgb at each active pixel.
    // stop_pix >= 0 returns right after that pixel's output is checked.
    task automatic run_frame(input int stop_pix);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 12; x++) begin
                de_in = (x < 8);
                hs_in = (x == 9 || x == 10);
                vs_in = 1'b0;
                x_in  = (x < 8) ? XB'(x) : '0;
                y_in  = YB'(y);
                step();
                if (x < 8) begin
                    chk($sformatf("rgb y%0d x%0d", y, x), 32'({r_out, g_out, b_out}), 32'(exp_pix[y*8+x]));
                    if (y*8 + x == stop_pix) return;
                end
                if (x == 0) chk("de_out active", 32'(de_out), 32'd1);
                if (x == 9) chk("hs_out", 32'(hs_out), 32'd1);
                if (y == 0 && x == 8) chk("rgb blank", 32'({r_out, g_out, b_out}), 32'd0);
            end
        end
        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < 12; x++) begin
                de_in = 1'b0;
                hs_in = (x == 9 || x == 10);
                vs_in = (l == 0);
                x_in  = '0;
                y_in  = '0;
                step();
                if (l == 0 && x == 0) chk("vs_out", 32'(vs_out), 32'd1);
            end
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b0; px_valid = 1'b0; px_data = '0; px_sof = 1'b0;
        drive_idle();
        idle(3);

        // Reset state
        chk("rst px_ready", 32'(px_ready), 32'd1);
        chk("rst fill", 32'(fill_level), 32'd0);
        chk("rst locked", 32'(locked), 32'd0);
        chk("rst de_out", 32'(de_out), 32'd0);
        chk("rst rgb", 32'({r_out, g_out, b_out}), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        step();

        // 1: preloaded full frame
        for (int n = 0; n < 32; n++) push(pix(n), n == 0);
        idle(3);
        chk("t1 fill", 32'(fill_level), 32'd32);
        chk("t1 state wait", 32'(dbg_state), 32'd1);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n);
        run_frame(-1);
        chk("t1 locked", 32'(locked), 32'd1);
        chk("t1 under", 32'(underflow_cnt), 32'd0);
        chk("t1 resync", 32'(resync_cnt), 32'd0);
        chk("t1 fill end", 32'(fill_level), 32'd0);

        // 2: stale pixels ahead of a frame are flushed in SEEK
        do_reset();
        for (int k = 0; k < 5; k++) push(pix(200 + k), 1'b0);
        for (int n = 0; n < 32; n++) push(pix(n + 32), n == 0);
        idle(3);
        chk("t2 fill", 32'(fill_level), 32'd32);
        chk("t2 state wait", 32'(dbg_state), 32'd1);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n + 32);
        run_frame(-1);
        chk("t2 resync", 32'(resync_cnt), 32'd0);
        chk("t2 locked", 32'(locked), 32'd1);

        // 3: short source frame underflows, next frame aligns
        do_reset();
        for (int n = 0; n < 30; n++) push(pix(n + 16), n == 0);
        for (int n = 0; n < 32; n++) exp_pix[n] = (n < 30) ? pix(n + 16) : 24'd0;
        run_frame(-1);
        chk("t3 under", 32'(underflow_cnt), 32'd2);
        chk("t3 locked", 32'(locked), 32'd1);
        chk("t3 resync", 32'(resync_cnt), 32'd0);
        for (int n = 0; n < 32; n++) push(pix(n + 48), n == 0);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n + 48);
        run_frame(-1);
        chk("t3 under next", 32'(underflow_cnt), 32'd2);
        chk("t3 resync next", 32'(resync_cnt), 32'd0);

        // 4: early sof at pixel 20
        for (int n = 0; n < 20; n++) push(pix(n + 96), n == 0);
        for (int n = 0; n < 32; n++) push(pix(n + 160), n == 0);
        for (int n = 0; n < 32; n++) exp_pix[n] = (n < 20) ? pix(n + 96) : 24'd0;
        run_frame(-1);
        chk("t4 resync", 32'(resync_cnt), 32'd1);
        chk("t4 unlocked", 32'(locked), 32'd0);
        chk("t4 state wait", 32'(dbg_state), 32'd1);
        chk("t4 fill", 32'(fill_level), 32'd32);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n + 160);
        run_frame(-1);
        chk("t4 relock", 32'(locked), 32'd1);
        chk("t4 resync after", 32'(resync_cnt), 32'd1);
        chk("t4 under after", 32'(underflow_cnt), 32'd2);

        // 6: asynchronous reset at x=3,y=1 while streaming
        for (int n = 0; n < 32; n++) push(pix(n + 8), n == 0);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n + 8);
        run_frame(11);
        reset = 1'b0;
        #1;
        chk("t6 de_out", 32'(de_out), 32'd0);
        chk("t6 rgb", 32'({r_out, g_out, b_out}), 32'd0);
        chk("t6 fill", 32'(fill_level), 32'd0);
        chk("t6 locked", 32'(locked), 32'd0);
        chk("t6 under", 32'(underflow_cnt), 32'd0);
        chk("t6 resync", 32'(resync_cnt), 32'd0);
        chk("t6 px_ready", 32'(px_ready), 32'd1);
        chk("t6 state", 32'(dbg_state), 32'd0);
        drive_idle();
        #2;
        reset = 1'b1;
        idle(2);
        chk("t6 state release", 32'(dbg_state), 32'd0);
        chk("t6 fill release", 32'(fill_level), 32'd0);

        // 5: fill to capacity, then drain one frame
        accepted = 0;
        px_valid = 1'b1;
        for (int n = 0; n < (1 << AW) + 3; n++) begin
            px_data = pix(n);
            px_sof  = (n == 0);
            if (n == (1 << AW)) begin
                chk("t5 ready full", 32'(px_ready), 32'd0);
                chk("t5 fill full", 32'(fill_level), 32'd2048);
            end
            if (px_ready) accepted++;
            step();
        end
        px_valid = 1'b0;
        chk("t5 accepted", 32'(accepted), 32'd2048);
        chk("t5 fill end", 32'(fill_level), 32'd2048);
        chk("t5 ready end", 32'(px_ready), 32'd0);
        for (int n = 0; n < 32; n++) exp_pix[n] = pix(n);
        run_frame(-1);
        chk("t5 fill drained", 32'(fill_level), 32'd2016);
        chk("t5 ready drained", 32'(px_ready), 32'd1);
        chk("t5 locked", 32'(locked), 32'd1);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
